// File: rtl/demux_user_sched.sv
// Per-slot user scheduler: walks enabled users in index order, strobes the
// context cache around each engine run, and aborts users that exceed a timeout.
module demux_user_sched #(
  parameter int MAX_USERS   = 40,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic                 i_core_clk,
  input  logic                 i_rx_rstn,
  input  logic                 i_slot_start,
  input  logic                 i_abort,
  input  logic [5:0]           i_num_users,
  input  logic [MAX_USERS-1:0] i_user_en_mask,
  input  logic                 i_eng_done,
  output logic                 o_demux_user_start,
  output logic                 o_demux_user_end,
  output logic [5:0]           o_demux_user_idx,
  output logic                 o_eng_go,
  output logic                 o_busy,
  output logic                 o_slot_done,
  output logic [5:0]           o_user_cnt,
  output logic                 o_err_timeout,
  output logic [5:0]           o_timeout_idx
);

  localparam logic [5:0]       MAX_U    = 6'(MAX_USERS);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEARCH, S_START, S_LOAD, S_RUN, S_END, S_DONE
  } state_t;

  state_t               state, state_n;
  logic [5:0]           idx;
  logic [5:0]           num_eff;
  logic [MAX_USERS-1:0] mask;
  logic [5:0]           user_cnt;
  logic [CNT_W-1:0]     timer;
  logic                 timer_hit;

  assign timer_hit = (timer == TMO_LAST);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (i_slot_start) state_n = S_SEARCH;
      S_SEARCH: begin
        if (idx >= num_eff)  state_n = S_DONE;
        else if (mask[idx])  state_n = S_START;
      end
      S_START:  state_n = S_LOAD;
      S_LOAD:   state_n = S_RUN;
      S_RUN: begin
        // Done is checked first so a completion on the last allowed cycle counts.
        if (i_eng_done)      state_n = S_END;
        else if (timer_hit)  state_n = S_SEARCH;
      end
      S_END:    state_n = S_SEARCH;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (state != S_IDLE && i_abort) state_n = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state         <= S_IDLE;
      idx           <= '0;
      num_eff       <= '0;
      mask          <= '0;
      user_cnt      <= '0;
      timer         <= '0;
      o_err_timeout <= 1'b0;
      o_timeout_idx <= '0;
    end else begin
      state <= state_n;
      timer <= (state == S_RUN && state_n == S_RUN) ? timer + 1'b1 : '0;

      if (state == S_IDLE && i_slot_start) begin
        num_eff  <= (i_num_users > MAX_U) ? MAX_U : i_num_users;
        mask     <= i_user_en_mask;
        idx      <= '0;
        user_cnt <= '0;
      end else if (state_n == S_SEARCH) begin
        // Skipped, timed-out and finished users all advance to the next index.
        idx <= idx + 1'b1;
      end

      if (state == S_RUN && state_n == S_SEARCH) begin
        o_err_timeout <= 1'b1;
        o_timeout_idx <= idx;
      end

      if (state_n == S_END) user_cnt <= user_cnt + 1'b1;
    end
  end

  // Strobes are registered from the next state so they line up with the state.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      o_demux_user_start <= 1'b0;
      o_demux_user_end   <= 1'b0;
      o_eng_go           <= 1'b0;
      o_busy             <= 1'b0;
      o_slot_done        <= 1'b0;
    end else begin
      o_demux_user_start <= (state_n == S_START);
      o_demux_user_end   <= (state_n == S_END);
      o_eng_go           <= (state_n == S_RUN);
      o_busy             <= (state_n != S_IDLE);
      o_slot_done        <= (state_n == S_DONE);
    end
  end

  assign o_demux_user_idx = idx;
  assign o_user_cnt       = user_cnt;

endmodule

// File: tb/tb_demux_user_sched.sv
// Self-checking bench for demux_user_sched: table of slot scenarios, a per-cycle
// trace model built from the scheduling rules, hand-written abort/reset cases.
module tb_demux_user_sched;

  localparam int TO = 8;

  logic        i_core_clk = 1'b0;
  logic        i_rx_rstn  = 1'b0;
  logic        i_slot_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [5:0]  i_num_users = '0;
  logic [39:0] i_user_en_mask = '0;
  logic        i_eng_done = 1'b0;
  logic        o_demux_user_start, o_demux_user_end, o_eng_go, o_busy;
  logic        o_slot_done, o_err_timeout;
  logic [5:0]  o_demux_user_idx, o_user_cnt, o_timeout_idx;

  demux_user_sched #(.MAX_USERS(40), .TIMEOUT_CYC(TO), .CNT_W(4)) dut (
    .i_core_clk         (i_core_clk),
    .i_rx_rstn          (i_rx_rstn),
    .i_slot_start       (i_slot_start),
    .i_abort            (i_abort),
    .i_num_users        (i_num_users),
    .i_user_en_mask     (i_user_en_mask),
    .i_eng_done         (i_eng_done),
    .o_demux_user_start (o_demux_user_start),
    .o_demux_user_end   (o_demux_user_end),
    .o_demux_user_idx   (o_demux_user_idx),
    .o_eng_go           (o_eng_go),
    .o_busy             (o_busy),
    .o_slot_done        (o_slot_done),
    .o_user_cnt         (o_user_cnt),
    .o_err_timeout      (o_err_timeout),
    .o_timeout_idx      (o_timeout_idx)
  );

  always #5 i_core_clk = ~i_core_clk;

  typedef struct {
    logic [5:0]  num;
    logic [39:0] mask;
    int          lat;
    int          to_user;
    int          first_start;
    int          done_t;
    int          cnt;
    logic        err;
    logic [5:0]  tidx;
  } vec_t;

  typedef struct {
    logic       busy, start, fin, go, sdone, err;
    logic [5:0] tidx, idx, cnt;
    logic       chk_idx, chk_cnt;
  } cyc_t;

  vec_t       tbl[8];
  cyc_t       exp_q[$];
  int         lat_arr[64];
  int         rc;
  bit         stray_en;
  logic       m_err;
  logic [5:0] m_tidx;
  int         n_chk, n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next negedge and play the engine: done after lat_arr[idx]
  // extra go cycles, with optional stray done pulses outside RUN.
  task automatic tick();
    @(negedge i_core_clk);
    if (o_eng_go) begin
      i_eng_done = (rc == lat_arr[o_demux_user_idx]);
      rc++;
    end else begin
      rc = 0;
      i_eng_done = stray_en && ($urandom_range(7) == 0);
    end
  endtask

  task automatic push_c(input logic busy, start, fin, go, sdone,
                        input logic [5:0] idx, input logic chk_idx,
                        input logic [5:0] cnt, input logic chk_cnt);
    cyc_t e;
    e.busy = busy; e.start = start; e.fin = fin; e.go = go; e.sdone = sdone;
    e.err = m_err; e.tidx = m_tidx; e.idx = idx; e.chk_idx = chk_idx;
    e.cnt = cnt; e.chk_cnt = chk_cnt;
    exp_q.push_back(e);
  endtask

  // Expected cycle-by-cycle trace of one slot, starting the cycle after slot_start.
  task automatic build_trace(input logic [5:0] num, input logic [39:0] mask);
    int ne, r;
    logic [5:0] cnt;
    ne  = (num > 40) ? 40 : int'(num);
    cnt = '0;
    exp_q.delete();
    for (int u = 0; u < ne; u++) begin
      push_c(1, 0, 0, 0, 0, 6'(u), 1, cnt, 1);
      if (mask[u]) begin
        push_c(1, 1, 0, 0, 0, 6'(u), 1, cnt, 1);
        push_c(1, 0, 0, 0, 0, 6'(u), 1, cnt, 1);
        r = (lat_arr[u] < TO) ? lat_arr[u] + 1 : TO;
        for (int j = 0; j < r; j++) push_c(1, 0, 0, 1, 0, 6'(u), 1, cnt, 1);
        if (lat_arr[u] < TO) begin
          push_c(1, 0, 1, 0, 0, 6'(u), 1, cnt, 0);
          cnt++;
        end else begin
          m_err  = 1'b1;
          m_tidx = 6'(u);
        end
      end
    end
    push_c(1, 0, 0, 0, 0, 6'(ne), 1, cnt, 1);
    push_c(1, 0, 0, 0, 1, 6'(ne), 1, cnt, 1);
    push_c(0, 0, 0, 0, 0, 6'(ne), 0, cnt, 1);
  endtask

  task automatic run_slot(input logic [5:0] num, input logic [39:0] mask,
                          output int done_t, output int first_start);
    cyc_t e;
    int k;
    logic [23:0] act, exp;
    build_trace(num, mask);
    tick();
    i_slot_start = 1'b1; i_num_users = num; i_user_en_mask = mask;
    done_t = 0; first_start = 0; k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      k++;
      i_slot_start = (stray_en && e.busy) ? ($urandom_range(7) == 0) : 1'b0;
      if (stray_en && e.busy) begin
        i_num_users    = 6'($urandom);
        i_user_en_mask = {8'($urandom), 32'($urandom)};
      end
      if (o_slot_done && done_t == 0) done_t = k;
      if (o_demux_user_start && first_start == 0) first_start = k;
      act = {o_busy, o_demux_user_start, o_demux_user_end, o_eng_go, o_slot_done,
             o_err_timeout, o_timeout_idx,
             e.chk_idx ? o_demux_user_idx : 6'd0, e.chk_cnt ? o_user_cnt : 6'd0};
      exp = {e.busy, e.start, e.fin, e.go, e.sdone, e.err, e.tidx,
             e.chk_idx ? e.idx : 6'd0, e.chk_cnt ? e.cnt : 6'd0};
      check($sformatf("trace n=%0d cyc%0d", num, k), 64'(act), 64'(exp));
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({o_demux_user_start, o_demux_user_end, o_demux_user_idx, o_eng_go,
                o_busy, o_slot_done, o_user_cnt, o_err_timeout, o_timeout_idx});
  endfunction

  initial begin
    int done_t, first_start, guard;
    n_chk = 0; n_err = 0; rc = 0; stray_en = 0;
    m_err = 0; m_tidx = '0;
    foreach (lat_arr[i]) lat_arr[i] = 0;

    //            num    mask              lat to  first done cnt err tidx
    tbl[0] = '{6'd2,  40'h3,             2, 63, 2, 16,  2, 0, 6'd0};
    tbl[1] = '{6'd40, 40'h80_0000_0020,  0, 63, 7, 50,  2, 0, 6'd0};
    tbl[2] = '{6'd63, 40'hFF_FFFF_FFFF,  0, 63, 2, 202, 40, 0, 6'd0};
    tbl[3] = '{6'd0,  40'hFF_FFFF_FFFF,  0, 63, 0, 2,   0, 0, 6'd0};
    tbl[4] = '{6'd40, 40'h0,             0, 63, 0, 42,  0, 0, 6'd0};
    tbl[5] = '{6'd1,  40'h1,             7, 63, 2, 14,  1, 0, 6'd0};
    tbl[6] = '{6'd5,  40'h18,            1, 3,  5, 22,  1, 1, 6'd3};
    tbl[7] = '{6'd2,  40'h3,             2, 63, 2, 16,  2, 1, 6'd3};

    #3;
    check("reset_outputs", all_outs(), 64'd0);
    @(negedge i_core_clk);
    i_rx_rstn = 1'b1;

    for (int t = 0; t < 8; t++) begin
      foreach (lat_arr[i]) lat_arr[i] = tbl[t].lat;
      if (tbl[t].to_user < 64) lat_arr[tbl[t].to_user] = 100;
      run_slot(tbl[t].num, tbl[t].mask, done_t, first_start);
      check($sformatf("tbl%0d done_t", t), 64'(done_t), 64'(tbl[t].done_t));
      check($sformatf("tbl%0d first_start", t), 64'(first_start), 64'(tbl[t].first_start));
      check($sformatf("tbl%0d user_cnt", t), 64'(o_user_cnt), 64'(tbl[t].cnt));
      check($sformatf("tbl%0d err", t), 64'(o_err_timeout), 64'(tbl[t].err));
      check($sformatf("tbl%0d tidx", t), 64'(o_timeout_idx), 64'(tbl[t].tidx));
    end

    // Stray done pulses in IDLE change nothing.
    for (int j = 0; j < 3; j++) begin
      tick();
      i_eng_done = 1'b1;
      check("idle_done_ignored", 64'({o_busy, o_demux_user_start, o_eng_go, o_slot_done}), 64'd0);
    end

    // Abort in RUN of user 2, then restart straight away.
    foreach (lat_arr[i]) lat_arr[i] = 1;
    lat_arr[2] = 20;
    tick();
    i_slot_start = 1'b1; i_num_users = 6'd4; i_user_en_mask = 40'hF;
    guard = 0;
    do begin
      tick();
      i_slot_start = 1'b0;
      guard++;
    end while (!(o_eng_go && o_demux_user_idx == 6'd2) && guard < 200);
    check("abort_reach_run2", 64'(guard < 200), 64'd1);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_idle", 64'({o_busy, o_eng_go, o_demux_user_end, o_slot_done}), 64'd0);
    check("abort_cnt", 64'(o_user_cnt), 64'd2);
    i_slot_start = 1'b1;
    lat_arr[0] = 3;
    tick();
    i_slot_start = 1'b0;
    check("restart_busy", 64'({o_busy, o_user_cnt}), 64'({1'b1, 6'd0}));

    // Abort and done in the same RUN cycle: abort wins.
    guard = 0;
    while (!o_eng_go && guard < 50) begin
      tick();
      guard++;
    end
    check("abort2_reach_run", 64'(o_eng_go), 64'd1);
    i_abort = 1'b1; i_eng_done = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      i_abort = 1'b0;
      check("abort_done_collide", 64'({o_busy, o_demux_user_end, o_slot_done, o_user_cnt}), 64'd0);
    end

    // Asynchronous reset in the middle of RUN.
    lat_arr[0] = 50;
    tick();
    i_slot_start = 1'b1; i_num_users = 6'd1; i_user_en_mask = 40'h1;
    guard = 0;
    do begin
      tick();
      i_slot_start = 1'b0;
      guard++;
    end while (!o_eng_go && guard < 20);
    check("rst_reach_run", 64'(o_eng_go), 64'd1);
    #1 i_rx_rstn = 1'b0;
    #1 check("async_reset_outputs", all_outs(), 64'd0);
    tick();
    tick();
    i_rx_rstn = 1'b1;
    m_err = 0; m_tidx = '0;

    // Random slots against the trace model, with stray inputs while busy.
    stray_en = 1;
    for (int s = 0; s < 25; s++) begin
      foreach (lat_arr[i]) lat_arr[i] = $urandom_range(0, 9);
      run_slot(6'($urandom_range(0, 63)), {8'($urandom), 32'($urandom)}, done_t, first_start);
      check($sformatf("rand%0d slot_done_seen", s), 64'(done_t > 0), 64'd1);
    end
    stray_en = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
